result_rr_merger: RTL

//  Merges the result FIFOs of NUM_CORES ray-tracing cores into one AXI4-Stream result channel toward the DMA.
//  - Core selection: round-robin, one beat per grant.
//  - Beat format: a 97-bit result {payload[95:0], hit} packed into 128 bits, with the source core id inserted.
//  - Framing: packets of BURST_LEN beats. A short packet is closed by an idle timeout, using a one-beat hold-back buffer.

---
 rtl/rtcore_result_pkg.sv | 35 +++
 rtl/result_rr_merger_rr_pick.sv | 44 ++++
 rtl/result_rr_merger.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rtcore_result_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtcore_result_pkg
// Description : Shared widths, merger FSM states and the result-to-AXIS beat
//               packer used by the result merging paths.
// Revision    : 1.0 - initial release
// ============================================================================
package rtcore_result_pkg;

    localparam int RESULT_W = 97;
    localparam int AXIS_W   = 128;
    localparam int ID_LSB   = 24;
    localparam int ID_W     = 8;

    // Merger state: whether the hold-back buffer currently owns a beat
    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_HOLD_V = 1'b1
    } merge_state_t;

    // {payload, hit} -> {payload, id, zeros, hit}
    function automatic logic [AXIS_W-1:0] pack_result(
        input logic [RESULT_W-1:0] result,
        input logic [ID_W-1:0]     id
    );
        logic [AXIS_W-1:0] beat;
        beat                   = '0;
        beat[AXIS_W-1:32]      = result[RESULT_W-1:1];
        beat[ID_LSB +: ID_W]   = id;
        beat[0]                = result[0];
        return beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_rr_merger_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin chooser. Returns the first active
//               request found when searching upward from ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Walk ptr, ptr+1, ... modulo NUM_REQ and latch onto the first requester
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!any && req[w_idx]) begin
                any        = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_rr_merger.sv
`default_nettype none
// ============================================================================
// Module      : result_rr_merger
// Description : Round-robin merge of per-core FWFT result FIFOs into one
//               AXI4-Stream channel. Packets close at BURST_LEN beats or, via a
//               one-beat hold-back buffer, after IDLE_TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module result_rr_merger
    import rtcore_result_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_CORES-1:0]          fifo_empty,
    input  logic [NUM_CORES*RESULT_W-1:0] fifo_dout,
    output logic [NUM_CORES-1:0]          fifo_read,
    output logic [AXIS_W-1:0]             m_axis_result_tdata,
    output logic [AXIS_W/8-1:0]           m_axis_result_tkeep,
    output logic                          m_axis_result_tlast,
    output logic                          m_axis_result_tvalid,
    input  logic                          m_axis_result_tready,
    output logic [31:0]                   stat_beats,
    output logic [31:0]                   stat_packets
);

    localparam int c_idx_w  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int c_beat_w = $clog2(BURST_LEN + 1);
    localparam int c_idle_w = $clog2(IDLE_TIMEOUT + 1);

    merge_state_t          r_state;
    merge_state_t          w_state_nxt;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [AXIS_W-1:0]     r_hold;
    logic [AXIS_W-1:0]     r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [c_beat_w-1:0]   r_beat_cnt;
    logic [c_idle_w-1:0]   r_idle_cnt;
    logic [31:0]           r_stat_beats;
    logic [31:0]           r_stat_packets;

    logic [RESULT_W-1:0]   w_core_dout [NUM_CORES];
    logic [NUM_CORES-1:0]  w_gnt;
    logic [c_idx_w-1:0]    w_gnt_idx;
    logic                  w_any;
    logic                  w_out_free;
    logic                  w_burst_end;
    logic                  w_idle_hit;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_load_last;
    logic [c_idx_w-1:0]    w_ptr_nxt;

    // Split the flat FIFO head bus into one entry per core
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_slice
        assign w_core_dout[g] = fifo_dout[g*RESULT_W +: RESULT_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_CORES),
        .IDX_W   (c_idx_w)
    ) u_pick (
        .req     (~fifo_empty),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_out_free  = !r_out_valid || m_axis_result_tready;
    assign w_burst_end = (r_beat_cnt == c_beat_w'(BURST_LEN - 1));
    assign w_idle_hit  = (r_idle_cnt == c_idle_w'(IDLE_TIMEOUT - 1));
    assign w_ptr_nxt   = (w_gnt_idx == c_idx_w'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Next-state and pop/load decisions; a pop always lands in HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_any) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_HOLD_V;
                end
            end
            ST_HOLD_V: begin
                if (w_any && w_out_free) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_load_last = w_burst_end;
                end else if (!w_any && w_out_free && w_idle_hit) begin
                    w_load      = 1'b1;
                    w_load_last = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD/OUT datapath, arbiter pointer, framing and statistics counters
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rr_ptr       <= '0;
            r_hold         <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_beat_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_stat_beats   <= '0;
            r_stat_packets <= '0;
        end else begin
            if (w_pop) begin
                r_hold   <= pack_result(w_core_dout[w_gnt_idx], ID_W'(w_gnt_idx));
                r_rr_ptr <= w_ptr_nxt;
            end

            if (w_load) begin
                r_out_data  <= r_hold;
                r_out_last  <= w_load_last;
                r_out_valid <= 1'b1;
                r_beat_cnt  <= w_load_last ? '0 : r_beat_cnt + 1'b1;
            end else if (m_axis_result_tready) begin
                r_out_valid <= 1'b0;
            end

            // Idle time only accrues while a beat waits in HOLD with no source
            if (w_any) begin
                r_idle_cnt <= '0;
            end else if (r_state == ST_HOLD_V && !w_idle_hit) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (r_out_valid && m_axis_result_tready) begin
                r_stat_beats <= r_stat_beats + 32'd1;
                if (r_out_last) begin
                    r_stat_packets <= r_stat_packets + 32'd1;
                end
            end
        end
    end

    assign fifo_read            = (w_pop && !areset) ? w_gnt : '0;
    assign m_axis_result_tdata  = r_out_data;
    assign m_axis_result_tkeep  = '1;
    assign m_axis_result_tlast  = r_out_last;
    assign m_axis_result_tvalid = r_out_valid;
    assign stat_beats           = r_stat_beats;
    assign stat_packets         = r_stat_packets;

endmodule
`default_nettype wire
